lc3b_store_queue: RTL and testbench
===================================

LC3B_STORE_QUEUE -- requirements
Module: lc3b_store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries (power of 2, >=2).
REQ-002 SHALL have parameter ROB_W, default 4, width of ROB ids; SQ index width is log2(DEPTH).
REQ-003 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: alloc_valid in 1; alloc_ready out 1 (not full); alloc_rob_id in ROB_W; alloc_op in 2 (0=STR, 1=STB, 2=STI); alloc_val_ready in 1; alloc_value in 16; alloc_val_rob_id in ROB_W; alloc_idx out log2(DEPTH) (tail slot).
REQ-005 SHALL have ports: agu_valid in 1; agu_idx in log2(DEPTH); agu_address in 16 (final address; STI already resolved).
REQ-006 SHALL have ports: cdb_ready in 1; cdb_dest in ROB_W; cdb_value in 16 (snooped result bus).
REQ-007 SHALL have ports: commit_valid in 1 (ROB retires oldest uncommitted store); flush in 1 (mispredict squash).
REQ-008 SHALL have ports: mem_write out 1; mem_address out 16; mem_wdata out 16; mem_wmask out 2; mem_resp in 1.
REQ-009 SHALL have ports: query_address in 16; query_conflict out 1; empty out 1.

Function
REQ-010 Circular buffer: head, tail pointers wrap modulo DEPTH; count 0..DEPTH; ccount (committed entries) 0..count; committed entries always contiguous from head.
REQ-011 alloc_ready = (count != DEPTH), combinational; alloc accepted on edge when alloc_valid & alloc_ready & !flush; writes slot tail, addr_ready=0, tail+1, count+1.
REQ-012 Alloc with alloc_val_ready=0 and same-cycle cdb_ready & cdb_dest==alloc_val_rob_id SHALL store cdb_value with val_ready=1.
REQ-013 Every valid entry with val_ready=0 and val_rob_id==cdb_dest on cdb_ready SHALL capture cdb_value, set val_ready=1 next edge.
REQ-014 agu_valid SHALL write address into agu_idx and set addr_ready=1; ignored if slot invalid.
REQ-015 commit_valid SHALL increment ccount; ignored when ccount==count.
REQ-016 FSM states IDLE, WRITE. IDLE->WRITE when ccount>0 and head has addr_ready & val_ready; WRITE->IDLE on mem_resp, which pops head (valid=0, head+1, count-1, ccount-1).
REQ-017 mem_write=1 only in WRITE; mem_address/mem_wdata/mem_wmask held stable from head throughout WRITE.
REQ-018 STR/STI: mem_address = address with bit0 forced 0, wmask=2'b11, wdata=value.
REQ-019 STB: mem_address = address with bit0 forced 0; bit0=0 -> wmask=2'b01, wdata={8'h00,value[7:0]}; bit0=1 -> wmask=2'b10, wdata={value[7:0],8'h00}.
REQ-020 flush SHALL invalidate all uncommitted entries next edge: tail=head+ccount, count=ccount; committed entries and WRITE state unaffected.
REQ-021 Same-cycle precedence: commit applied before flush; flush drops same-cycle alloc; pop and alloc same cycle both apply (count unchanged); pop and flush same cycle give count=ccount-1.
REQ-022 query_conflict (combinational) = 1 if any valid entry has addr_ready=0 or address[15:1]==query_address[15:1].
REQ-023 empty = (count==0).

Reset
REQ-024 On reset: head=tail=count=ccount=0, all valid=0, FSM=IDLE, mem_write=0, mem_address/mem_wdata/mem_wmask=0, alloc_ready=1, empty=1, query_conflict=0, alloc_idx=0.
REQ-025 reset asserted mid-WRITE SHALL abort immediately; pending mem_resp after reset ignored.

Verification
REQ-026 Alloc STR rob 3 value 16'h1234 ready, agu 16'h3001, commit -> mem_write with address 16'h3000, wdata 16'h1234, wmask 2'b11; mem_resp -> empty=1.
REQ-027 Alloc STB value 16'h00AB, address 16'h2005, commit -> wmask 2'b10, wdata 16'hAB00, address 16'h2004.
REQ-028 Alloc with val_rob_id 5 unready, cdb_dest 5 value 16'hBEEF same cycle -> entry value 16'hBEEF, write occurs after address+commit.
REQ-029 Fill DEPTH=8 entries -> alloc_ready=0, extra alloc dropped; pop with alloc same cycle -> count stays 8, tail wraps to 1.
REQ-030 Alloc 4, commit 1, flush with commit same cycle -> count=2, tail=head+2; mem_write in progress completes unchanged.

Source files
------------

// File: rtl/lc3b_store_queue.sv
// In-order store queue for the LC-3b out-of-order core. Entries are allocated at dispatch,
// resolve their address and data out of order, and drain to memory in order once committed.
module lc3b_store_queue #(
    parameter int DEPTH = 8,
    parameter int ROB_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [ROB_W-1:0]         alloc_rob_id,
    input  logic [1:0]               alloc_op,
    input  logic                     alloc_val_ready,
    input  logic [15:0]              alloc_value,
    input  logic [ROB_W-1:0]         alloc_val_rob_id,
    output logic [$clog2(DEPTH)-1:0] alloc_idx,
    input  logic                     agu_valid,
    input  logic [$clog2(DEPTH)-1:0] agu_idx,
    input  logic [15:0]              agu_address,
    input  logic                     cdb_ready,
    input  logic [ROB_W-1:0]         cdb_dest,
    input  logic [15:0]              cdb_value,
    input  logic                     commit_valid,
    input  logic                     flush,
    output logic                     mem_write,
    output logic [15:0]              mem_address,
    output logic [15:0]              mem_wdata,
    output logic [1:0]               mem_wmask,
    input  logic                     mem_resp,
    input  logic [15:0]              query_address,
    output logic                     query_conflict,
    output logic                     empty
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [1:0] OP_STB = 2'd1;

    typedef enum logic {IDLE, WRITE} state_t;
    state_t state, state_next;

    logic [IW-1:0]    head, tail;
    logic [IW:0]      count, ccount, ccount_c;
    logic [DEPTH-1:0] ent_valid, ent_addr_ready, ent_val_ready, keep;
    logic [1:0]       ent_op      [DEPTH];
    logic [15:0]      ent_value   [DEPTH];
    logic [15:0]      ent_address [DEPTH];
    logic [ROB_W-1:0] ent_val_rob [DEPTH];
    logic             do_alloc, do_pop, do_commit, head_ready;
    logic [IW-1:0]    off;
    logic             unused_ok;

    assign alloc_ready = (count != (IW+1)'(DEPTH));
    assign alloc_idx   = tail;
    assign empty       = (count == '0);
    assign mem_write   = (state == WRITE);
    assign do_alloc    = alloc_valid && alloc_ready && !flush;
    assign do_pop      = (state == WRITE) && mem_resp;
    assign do_commit   = commit_valid && (ccount != count);
    assign ccount_c    = ccount + (IW+1)'(do_commit);
    assign head_ready  = ent_valid[head] && ent_addr_ready[head] && ent_val_ready[head];
    assign unused_ok   = ^{alloc_rob_id, query_address[0]};

    // Entries at or beyond head+ccount (after this cycle's commit) are the ones a flush drops.
    always_comb begin
        keep = '0;
        off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off     = IW'(i) - head;
            keep[i] = ({1'b0, off} < ccount_c);
        end
    end

    always_comb begin
        query_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (!ent_addr_ready[i] ||
                                 ent_address[i][15:1] == query_address[15:1]))
                query_conflict = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ccount != '0 && head_ready) state_next = WRITE;
            WRITE:   if (mem_resp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory request is captured once on entry to WRITE so it cannot move while the write is outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
        end else if (state == IDLE && state_next == WRITE) begin
            mem_address <= {ent_address[head][15:1], 1'b0};
            if (ent_op[head] == OP_STB) begin
                mem_wmask <= ent_address[head][0] ? 2'b10 : 2'b01;
                mem_wdata <= ent_address[head][0] ? {ent_value[head][7:0], 8'h00}
                                                  : {8'h00, ent_value[head][7:0]};
            end else begin
                mem_wmask <= 2'b11;
                mem_wdata <= ent_value[head];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            ccount         <= '0;
            ent_valid      <= '0;
            ent_addr_ready <= '0;
            ent_val_ready  <= '0;
        end else begin
            head   <= head + IW'(do_pop);
            ccount <= ccount_c - (IW+1)'(do_pop);
            if (flush) begin
                tail  <= head + ccount_c[IW-1:0];
                count <= ccount_c - (IW+1)'(do_pop);
            end else begin
                tail  <= tail + IW'(do_alloc);
                count <= count + (IW+1)'(do_alloc) - (IW+1)'(do_pop);
            end

            for (int i = 0; i < DEPTH; i++) begin
                if (flush && !keep[i])
                    ent_valid[i] <= 1'b0;
                if (cdb_ready && ent_valid[i] && !ent_val_ready[i] && ent_val_rob[i] == cdb_dest) begin
                    ent_value[i]     <= cdb_value;
                    ent_val_ready[i] <= 1'b1;
                end
            end

            if (do_pop)
                ent_valid[head] <= 1'b0;

            if (agu_valid && ent_valid[agu_idx]) begin
                ent_address[agu_idx]    <= agu_address;
                ent_addr_ready[agu_idx] <= 1'b1;
            end

            // A new entry can pick its data straight off the CDB in the cycle it is allocated.
            if (do_alloc) begin
                ent_valid[tail]      <= 1'b1;
                ent_addr_ready[tail] <= 1'b0;
                ent_op[tail]         <= alloc_op;
                ent_val_rob[tail]    <= alloc_val_rob_id;
                if (alloc_val_ready) begin
                    ent_value[tail]     <= alloc_value;
                    ent_val_ready[tail] <= 1'b1;
                end else if (cdb_ready && cdb_dest == alloc_val_rob_id) begin
                    ent_value[tail]     <= cdb_value;
                    ent_val_ready[tail] <= 1'b1;
                end else begin
                    ent_value[tail]     <= alloc_value;
                    ent_val_ready[tail] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_lc3b_store_queue.sv
// Scoreboard bench for lc3b_store_queue: directed stores push expected memory writes,
// a monitor pops and compares each write the DUT issues.
module tb_lc3b_store_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid, alloc_ready, alloc_val_ready;
    logic [3:0]  alloc_rob_id, alloc_val_rob_id;
    logic [1:0]  alloc_op;
    logic [15:0] alloc_value;
    logic [2:0]  alloc_idx, agu_idx;
    logic        agu_valid;
    logic [15:0] agu_address;
    logic        cdb_ready;
    logic [3:0]  cdb_dest;
    logic [15:0] cdb_value;
    logic        commit_valid, flush;
    logic        mem_write;
    logic [15:0] mem_address, mem_wdata;
    logic [1:0]  mem_wmask;
    logic        mem_resp_auto, mem_resp_force;
    logic [15:0] query_address;
    logic        query_conflict, empty;

    int          total = 0;
    int          bad = 0;
    logic [33:0] exp_q[$];
    bit          resp_en = 1'b0;
    int          wcnt = 0;
    bit          in_write = 1'b0;
    logic [33:0] cur_txn, exp_txn;

    always #5 clk = ~clk;

    lc3b_store_queue dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rob_id(alloc_rob_id),
        .alloc_op(alloc_op), .alloc_val_ready(alloc_val_ready), .alloc_value(alloc_value),
        .alloc_val_rob_id(alloc_val_rob_id), .alloc_idx(alloc_idx),
        .agu_valid(agu_valid), .agu_idx(agu_idx), .agu_address(agu_address),
        .cdb_ready(cdb_ready), .cdb_dest(cdb_dest), .cdb_value(cdb_value),
        .commit_valid(commit_valid), .flush(flush),
        .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp(mem_resp_auto | mem_resp_force),
        .query_address(query_address), .query_conflict(query_conflict), .empty(empty)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One cycle of control inputs; every strobe is dropped again afterwards.
    task automatic applyStimulus(input logic a_v, input logic [1:0] op, input logic vr,
                                 input logic [15:0] val, input logic [3:0] vrob,
                                 input logic g_v, input logic [2:0] g_i, input logic [15:0] g_a,
                                 input logic c_v, input logic f_v,
                                 input logic cb_v, input logic [3:0] cb_d, input logic [15:0] cb_val);
        alloc_valid = a_v; alloc_op = op; alloc_val_ready = vr; alloc_value = val;
        alloc_val_rob_id = vrob; alloc_rob_id = vrob + 4'd1;
        agu_valid = g_v; agu_idx = g_i; agu_address = g_a;
        commit_valid = c_v; flush = f_v;
        cdb_ready = cb_v; cdb_dest = cb_d; cdb_value = cb_val;
        step();
        alloc_valid = 1'b0; agu_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0; cdb_ready = 1'b0;
    endtask

    task automatic allocStore(input logic [1:0] op, input logic [15:0] val);
        applyStimulus(1'b1, op, 1'b1, val, 4'd0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    endtask

    task automatic aguWrite(input logic [2:0] idx, input logic [15:0] addr);
        applyStimulus(1'b0, 2'd0, 1'b0, 16'h0, 4'd0, 1'b1, idx, addr, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    endtask

    task automatic commitOne();
        applyStimulus(1'b0, 2'd0, 1'b0, 16'h0, 4'd0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
    endtask

    task automatic cdbDrive(input logic [3:0] dest, input logic [15:0] val);
        applyStimulus(1'b0, 2'd0, 1'b0, 16'h0, 4'd0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1, dest, val);
    endtask

    task automatic expectWrite(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] mask);
        exp_q.push_back({addr, data, mask});
    endtask

    task automatic queryCheck(input string name, input logic [15:0] addr, input logic expected);
        query_address = addr;
        #1;
        checkOutput(name, 16'(query_conflict), 16'(expected));
        query_address = 16'h0;
    endtask

    task automatic waitWrite(input string name, input int limit);
        int n = 0;
        while (!mem_write && n < limit) begin
            step();
            n++;
        end
        checkOutput(name, 16'(mem_write), 16'd1);
    endtask

    task automatic waitEmpty(input string name, input int limit);
        int n = 0;
        while (!empty && n < limit) begin
            step();
            n++;
        end
        checkOutput(name, 16'(empty), 16'd1);
    endtask

    // Memory model: answers three cycles into a write while enabled.
    initial begin
        mem_resp_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_write && resp_en && !mem_resp_auto) begin
                if (wcnt == 2) mem_resp_auto = 1'b1;
                else           wcnt++;
            end else begin
                mem_resp_auto = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: each new write is matched against the scoreboard, then held values are checked.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_write) begin
                if (!in_write) begin
                    in_write = 1'b1;
                    cur_txn = {mem_address, mem_wdata, mem_wmask};
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL unexpected_write: got addr=%h data=%h mask=%b, required no write",
                                 mem_address, mem_wdata, mem_wmask);
                    end else begin
                        exp_txn = exp_q.pop_front();
                        if (cur_txn !== exp_txn) begin
                            bad++;
                            $display("[TB] FAIL mem_txn: got addr=%h data=%h mask=%b, required addr=%h data=%h mask=%b",
                                     cur_txn[33:18], cur_txn[17:2], cur_txn[1:0],
                                     exp_txn[33:18], exp_txn[17:2], exp_txn[1:0]);
                        end
                    end
                end else begin
                    total++;
                    if ({mem_address, mem_wdata, mem_wmask} !== cur_txn) begin
                        bad++;
                        $display("[TB] FAIL mem_hold: got %h, required %h",
                                 {mem_address, mem_wdata, mem_wmask}, cur_txn);
                    end
                end
            end else begin
                in_write = 1'b0;
            end
        end
    end

    initial begin
        reset = 1'b1; alloc_valid = 1'b0; alloc_op = 2'd0; alloc_val_ready = 1'b0;
        alloc_value = 16'h0; alloc_rob_id = 4'd0; alloc_val_rob_id = 4'd0;
        agu_valid = 1'b0; agu_idx = 3'd0; agu_address = 16'h0;
        cdb_ready = 1'b0; cdb_dest = 4'd0; cdb_value = 16'h0;
        commit_valid = 1'b0; flush = 1'b0; mem_resp_force = 1'b0; query_address = 16'h0;
        idle(2);
        reset = 1'b0;
        checkOutput("rst_mem_write", 16'(mem_write), 16'd0);
        checkOutput("rst_mem_address", mem_address, 16'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 16'h0);
        checkOutput("rst_mem_wmask", 16'(mem_wmask), 16'd0);
        checkOutput("rst_alloc_ready", 16'(alloc_ready), 16'd1);
        checkOutput("rst_empty", 16'(empty), 16'd1);
        checkOutput("rst_alloc_idx", 16'(alloc_idx), 16'd0);
        queryCheck("rst_query", 16'h0000, 1'b0);

        // Word store, odd address aligned down.
        resp_en = 1'b1;
        applyStimulus(1'b1, 2'd0, 1'b1, 16'h1234, 4'd3, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
        checkOutput("a_alloc_idx", 16'(alloc_idx), 16'd1);
        checkOutput("a_not_empty", 16'(empty), 16'd0);
        queryCheck("a_query_unresolved", 16'h7000, 1'b1);
        aguWrite(3'd0, 16'h3001);
        queryCheck("a_query_hit", 16'h3000, 1'b1);
        queryCheck("a_query_miss", 16'h3002, 1'b0);
        expectWrite(16'h3000, 16'h1234, 2'b11);
        commitOne();
        waitEmpty("a_drain", 20);

        // Byte stores at odd and even addresses, then an STI word store.
        allocStore(2'd1, 16'h00AB);
        allocStore(2'd1, 16'h12CD);
        allocStore(2'd2, 16'h5A5A);
        aguWrite(3'd1, 16'h2005);
        aguWrite(3'd2, 16'h2006);
        aguWrite(3'd3, 16'h4443);
        expectWrite(16'h2004, 16'hAB00, 2'b10);
        expectWrite(16'h2006, 16'h00CD, 2'b01);
        expectWrite(16'h4442, 16'h5A5A, 2'b11);
        commitOne(); commitOne(); commitOne();
        waitEmpty("b_drain", 40);

        // Data from the CDB: same-cycle capture at alloc, then a later snoop.
        applyStimulus(1'b1, 2'd0, 1'b0, 16'h0000, 4'd5, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1, 4'd5, 16'hBEEF);
        aguWrite(3'd4, 16'h1000);
        expectWrite(16'h1000, 16'hBEEF, 2'b11);
        commitOne();
        waitEmpty("c_alloc_cdb", 20);
        applyStimulus(1'b1, 2'd0, 1'b0, 16'h0000, 4'd7, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
        aguWrite(3'd5, 16'h1100);
        commitOne();
        idle(4);
        checkOutput("c_wait_data", 16'(empty), 16'd0);
        cdbDrive(4'd6, 16'h1111);
        idle(3);
        checkOutput("c_wrong_tag", 16'(empty), 16'd0);
        expectWrite(16'h1100, 16'hCAFE, 2'b11);
        cdbDrive(4'd7, 16'hCAFE);
        waitEmpty("c_snoop", 20);

        // Fill all eight slots (head=tail=6), overflow, then pop with a same-cycle alloc.
        resp_en = 1'b0;
        for (int i = 0; i < 8; i++) allocStore(2'd0, 16'h0100 + 16'(i));
        checkOutput("d_full_ready", 16'(alloc_ready), 16'd0);
        checkOutput("d_full_idx", 16'(alloc_idx), 16'd6);
        allocStore(2'd0, 16'hFFFF);
        checkOutput("d_overflow_idx", 16'(alloc_idx), 16'd6);
        for (int i = 0; i < 8; i++) aguWrite(3'(6 + i), 16'h5000 + 16'(2 * i));
        expectWrite(16'h5000, 16'h0100, 2'b11);
        expectWrite(16'h5002, 16'h0101, 2'b11);
        commitOne(); commitOne();
        waitWrite("d_write1", 10);
        mem_resp_force = 1'b1;
        step();
        mem_resp_force = 1'b0;
        checkOutput("d_pop_ready", 16'(alloc_ready), 16'd1);
        checkOutput("d_pop_idx", 16'(alloc_idx), 16'd6);
        waitWrite("d_write2", 10);
        mem_resp_force = 1'b1;
        allocStore(2'd0, 16'h0200);
        mem_resp_force = 1'b0;
        checkOutput("d_pop_alloc_idx", 16'(alloc_idx), 16'd7);
        checkOutput("d_pop_alloc_ready", 16'(alloc_ready), 16'd1);
        allocStore(2'd0, 16'h0201);
        checkOutput("d_wrap_idx", 16'(alloc_idx), 16'd0);
        checkOutput("d_refull_ready", 16'(alloc_ready), 16'd0);

        // Commit + flush together keeps exactly one entry (slot 0, address 5004).
        resp_en = 1'b1;
        expectWrite(16'h5004, 16'h0102, 2'b11);
        applyStimulus(1'b0, 2'd0, 1'b0, 16'h0, 4'd0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0);
        checkOutput("e_flush_idx", 16'(alloc_idx), 16'd1);
        checkOutput("e_flush_ready", 16'(alloc_ready), 16'd1);
        queryCheck("e_flushed_gone", 16'h5006, 1'b0);
        queryCheck("e_kept_hit", 16'h5004, 1'b1);
        waitEmpty("e_drain", 20);

        // Four entries, one committed and writing; commit+flush+alloc in one cycle.
        resp_en = 1'b0;
        for (int i = 0; i < 4; i++) allocStore(2'd0, 16'hA000 + 16'(i));
        for (int i = 0; i < 4; i++) aguWrite(3'(1 + i), 16'h6000 + 16'(2 * i));
        expectWrite(16'h6000, 16'hA000, 2'b11);
        commitOne();
        waitWrite("f_write", 10);
        applyStimulus(1'b1, 2'd0, 1'b1, 16'hDEAD, 4'd0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0);
        checkOutput("f_flush_tail", 16'(alloc_idx), 16'd3);
        checkOutput("f_write_kept", 16'(mem_write), 16'd1);
        expectWrite(16'h6002, 16'hA001, 2'b11);
        queryCheck("f_flushed_gone", 16'h6004, 1'b0);
        queryCheck("f_committed_hit", 16'h6002, 1'b1);
        idle(2);
        resp_en = 1'b1;
        waitEmpty("f_drain", 30);
        checkOutput("f_final_idx", 16'(alloc_idx), 16'd3);

        // Reset in the middle of a write, stray response afterwards, commit on empty ignored.
        resp_en = 1'b0;
        allocStore(2'd0, 16'h7777);
        aguWrite(3'd3, 16'h7000);
        expectWrite(16'h7000, 16'h7777, 2'b11);
        commitOne();
        waitWrite("g_write", 10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("g_abort_write", 16'(mem_write), 16'd0);
        checkOutput("g_abort_empty", 16'(empty), 16'd1);
        checkOutput("g_abort_idx", 16'(alloc_idx), 16'd0);
        checkOutput("g_abort_addr", mem_address, 16'h0);
        checkOutput("g_abort_mask", 16'(mem_wmask), 16'd0);
        mem_resp_force = 1'b1;
        commitOne();
        mem_resp_force = 1'b0;
        resp_en = 1'b1;
        allocStore(2'd0, 16'h0042);
        aguWrite(3'd0, 16'h0010);
        idle(5);
        checkOutput("g_uncommitted_held", 16'(empty), 16'd0);
        expectWrite(16'h0010, 16'h0042, 2'b11);
        commitOne();
        waitEmpty("g_drain", 20);

        idle(2);
        checkOutput("sb_leftover", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
